// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, MEM and RAM-side signals of mem_port_arbiter.
// The arbiter connects to the slave modport; the requesters and RAM model connect to master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_data;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              busy_o;

    modport slave (
        input  if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        output if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy_o
    );

    modport master (
        output if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between IF and MEM, serialising 1/2/4-byte accesses.
// Define MEM_ARB_RR_EN for round-robin conflict resolution; default is fixed MEM priority.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    generate
        if (RAM_RD_LAT != 1) begin : g_lat_check
            $error("mem_port_arbiter: only RAM_RD_LAT = 1 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [2:0]        n_reg;
    logic              gnt_mem_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       data_reg;
    logic [ADDR_W-1:0] ram_a_hold_reg;
    logic [7:0]        ram_dout_hold_reg;

    logic              if_ok, pick_mem, pick_if, grant;
    logic [2:0]        mem_n;
    logic              issue;
    logic [ADDR_W-1:0] ram_a_cur;
    logic [7:0]        ram_dout_cur;
    logic [3:0]        cap_en;

`ifdef MEM_ARB_RR_EN
    // 1 = MEM was granted last; resets to IF so the first conflict goes to MEM
    logic last_grant_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b0;
        end else if (grant) begin
            last_grant_reg <= pick_mem;
        end
    end

    assign pick_mem = bus.mem_req & ~(if_ok & last_grant_reg);
`else
    assign pick_mem = bus.mem_req;
`endif

    assign if_ok   = bus.if_req & ~bus.if_flush;
    assign pick_if = if_ok & ~pick_mem;
    assign grant   = (state_reg == IDLE) & (pick_mem | pick_if);
    assign mem_n   = (bus.mem_len == 2'b00) ? 3'd1 : (bus.mem_len == 2'b01) ? 3'd2 : 3'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = 3'd0;
                if (pick_mem) begin
                    state_next = bus.mem_we ? WR : RD;
                end else if (pick_if) begin
                    state_next = RD;
                end
            end
            RD: begin
                // Read data trails the address by one cycle, hence the extra cnt == N step
                if (!gnt_mem_reg && bus.if_flush) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else if (cnt_reg == n_reg) begin
                    state_next = DONE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            WR: begin
                if (cnt_reg == n_reg - 3'd1) begin
                    state_next = DONE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign issue        = ((state_reg == RD) && (cnt_reg < n_reg)) || (state_reg == WR);
    assign ram_a_cur    = issue ? base_reg + ADDR_W'(cnt_reg) : ram_a_hold_reg;
    assign ram_dout_cur = (state_reg == WR) ? wdata_reg[{cnt_reg[1:0], 3'b000} +: 8]
                                            : ram_dout_hold_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cap
            assign cap_en[gi] = (state_reg == RD) && (cnt_reg == 3'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_mem_reg       <= 1'b0;
            we_reg            <= 1'b0;
            n_reg             <= 3'd4;
            base_reg          <= '0;
            wdata_reg         <= '0;
            data_reg          <= '0;
            ram_a_hold_reg    <= '0;
            ram_dout_hold_reg <= '0;
        end else begin
            ram_a_hold_reg    <= ram_a_cur;
            ram_dout_hold_reg <= ram_dout_cur;
            if (grant) begin
                gnt_mem_reg <= pick_mem;
                we_reg      <= pick_mem & bus.mem_we;
                n_reg       <= pick_mem ? mem_n : 3'd4;
                base_reg    <= pick_mem ? bus.mem_addr : bus.if_addr;
                wdata_reg   <= bus.mem_wdata;
                data_reg    <= '0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (cap_en[i]) begin
                        data_reg[8*i +: 8] <= bus.ram_din;
                    end
                end
            end
        end
    end

    assign bus.ram_a     = ram_a_cur;
    assign bus.ram_wr    = (state_reg == WR);
    assign bus.ram_dout  = ram_dout_cur;
    assign bus.busy_o    = (state_reg != IDLE);
    assign bus.if_done   = (state_reg == DONE) & ~gnt_mem_reg;
    assign bus.mem_done  = (state_reg == DONE) & gnt_mem_reg;
    assign bus.if_data   = bus.if_done ? data_reg : 32'h0;
    assign bus.mem_rdata = (bus.mem_done && !we_reg) ? data_reg : 32'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: byte RAM model plus a scoreboard of expected completions.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    mem_port_arbiter_if #(.ADDR_W(32)) bus();

    mem_port_arbiter #(.ADDR_W(32), .RAM_RD_LAT(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read, one cycle latency; preload port for the bench
    logic [7:0]  ram [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (bus.ram_wr) ram[bus.ram_a[15:0]] <= bus.ram_dout;
        bus.ram_din <= ram[bus.ram_a[15:0]];
    end

    typedef struct {
        bit          is_mem;
        bit          chk;
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } txn_t;

    bit          d_seen;
    bit          d_mem;
    logic [31:0] d_data;
    int          d_cyc;
    int          g;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_en   = 1'b0;
    endtask

    // Waits for the next done pulse, records it and drops that requester's req
    task automatic wait_done(input int budget);
        d_seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.if_done || bus.mem_done) begin
                d_seen = 1'b1;
                d_mem  = bus.mem_done;
                d_data = bus.mem_done ? bus.mem_rdata : bus.if_data;
                d_cyc  = cyc;
                if (bus.mem_done) bus.mem_req = 1'b0;
                else              bus.if_req  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        tests_run++;
        if (bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %0b expected 0", bus.busy_o);
        end
        tests_run++;
        if ({bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_done, bus.mem_done, bus.if_data, bus.mem_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ram_a=%h ram_wr=%0b ram_dout=%h if_done=%0b mem_done=%0b expected all 0",
                     bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_done, bus.mem_done);
        end
        step();
        rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_if_fetch();
        preload(16'h0100, 8'h13);
        preload(16'h0101, 8'h00);
        preload(16'h0102, 8'h50);
        preload(16'h0103, 8'h00);
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        g = cyc;
        sb.push_back('{1'b0, 1'b1, 32'h00500013, 6});
        for (int rel = 0; rel <= 4; rel++) begin
            @(negedge clk);
            if (rel == 0) begin
                tests_run++;
                if (bus.busy_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fetch_grant_busy: got %0b expected 0", bus.busy_o);
                end
            end else begin
                tests_run++;
                if (bus.ram_a !== 32'h100 + 32'(rel - 1) || bus.ram_wr !== 1'b0 || bus.busy_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL fetch_addr G+%0d: ram_a=%h wr=%0b busy=%0b expected ram_a=%h wr=0 busy=1",
                             rel, bus.ram_a, bus.ram_wr, bus.busy_o, 32'h100 + 32'(rel - 1));
                end
            end
        end
        wait_done(10);
        e = sb.pop_front();
        tests_run++;
        if (d_seen !== 1'b1 || d_mem !== e.is_mem || d_data !== e.data || d_cyc - g !== e.lat) begin
            tests_failed++;
            $display("FAIL fetch_done: seen=%0b mem=%0b data=%h lat=%0d expected mem=%0b data=%h lat=%0d",
                     d_seen, d_mem, d_data, d_cyc - g, e.is_mem, e.data, e.lat);
        end
        $display("[TB] if fetch 0x100 -> data=%h latency=%0d", d_data, d_cyc - g);
        step();
    endtask

    task automatic test_store_word();
        logic [31:0] wd;
        wd = 32'hDEADBEEF;
        step();
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_len   = 2'b10;
        bus.mem_addr  = 32'h2000;
        bus.mem_wdata = wd;
        g = cyc;
        sb.push_back('{1'b1, 1'b0, 32'h0, 5});
        for (int rel = 0; rel <= 4; rel++) begin
            @(negedge clk);
            if (rel > 0) begin
                tests_run++;
                if (bus.ram_wr !== 1'b1 || bus.ram_dout !== wd[8*(rel-1) +: 8] || bus.ram_a !== 32'h2000 + 32'(rel - 1)) begin
                    tests_failed++;
                    $display("FAIL store_byte G+%0d: wr=%0b dout=%h a=%h expected wr=1 dout=%h a=%h",
                             rel, bus.ram_wr, bus.ram_dout, bus.ram_a, wd[8*(rel-1) +: 8], 32'h2000 + 32'(rel - 1));
                end
            end
        end
        wait_done(8);
        bus.mem_we = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if (d_seen !== 1'b1 || d_mem !== e.is_mem || d_cyc - g !== e.lat) begin
            tests_failed++;
            $display("FAIL store_done: seen=%0b mem=%0b lat=%0d expected mem=1 lat=%0d",
                     d_seen, d_mem, d_cyc - g, e.lat);
        end
        @(negedge clk);
        tests_run++;
        if (bus.busy_o !== 1'b0 || bus.ram_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_after: busy=%0b wr=%0b expected 0 0", bus.busy_o, bus.ram_wr);
        end
        $display("[TB] mem store word %h @2000 latency=%0d", wd, d_cyc - g);
    endtask

    task automatic test_table();
        txn_t tbl[6];
        tbl[0] = '{1'b1, 1'b0, 2'b00, 32'h3001, 32'h0, 32'h000000F0, 3};
        tbl[1] = '{1'b1, 1'b0, 2'b01, 32'h3001, 32'h0, 32'h0000AAF0, 4};
        tbl[2] = '{1'b1, 1'b0, 2'b11, 32'h2000, 32'h0, 32'hDEADBEEF, 6};
        tbl[3] = '{1'b1, 1'b1, 2'b00, 32'h4000, 32'h55667777, 32'h0, 2};
        tbl[4] = '{1'b1, 1'b0, 2'b00, 32'h4000, 32'h0, 32'h00000077, 3};
        tbl[5] = '{1'b0, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, 32'h44332211, 6};
        preload(16'h3001, 8'hF0);
        preload(16'h3002, 8'hAA);
        preload(16'hFFFE, 8'h11);
        preload(16'hFFFF, 8'h22);
        preload(16'h0000, 8'h33);
        preload(16'h0001, 8'h44);
        for (int i = 0; i < 6; i++) begin
            step();
            if (tbl[i].is_mem) begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = tbl[i].we;
                bus.mem_len   = tbl[i].len;
                bus.mem_addr  = tbl[i].addr;
                bus.mem_wdata = tbl[i].wdata;
            end else begin
                bus.if_req  = 1'b1;
                bus.if_addr = tbl[i].addr;
            end
            g = cyc;
            sb.push_back('{tbl[i].is_mem, ~tbl[i].we, tbl[i].exp, tbl[i].lat});
            wait_done(12);
            bus.mem_we = 1'b0;
            e = sb.pop_front();
            tests_run++;
            if (d_seen !== 1'b1 || d_mem !== e.is_mem || d_cyc - g !== e.lat || (e.chk && d_data !== e.data)) begin
                tests_failed++;
                $display("FAIL table[%0d]: seen=%0b mem=%0b data=%h lat=%0d expected mem=%0b data=%h lat=%0d",
                         i, d_seen, d_mem, d_data, d_cyc - g, e.is_mem, e.data, e.lat);
            end
            $display("[TB] txn %0d mem=%0b we=%0b len=%0d addr=%h -> data=%h latency=%0d",
                     i, tbl[i].is_mem, tbl[i].we, tbl[i].len, tbl[i].addr, d_data, d_cyc - g);
            step();
        end
    endtask

    task automatic test_conflict();
        preload(16'h0500, 8'h01);
        preload(16'h0501, 8'h02);
        preload(16'h0502, 8'h03);
        preload(16'h0503, 8'h04);
        step();
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h100;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_len  = 2'b10;
        bus.mem_addr = 32'h500;
        g = cyc;
        sb.push_back('{1'b1, 1'b1, 32'h04030201, 6});
        sb.push_back('{1'b0, 1'b1, 32'h00500013, 13});
        for (int n = 0; n < 2; n++) begin
            wait_done(12);
            e = sb.pop_front();
            tests_run++;
            if (d_seen !== 1'b1 || d_mem !== e.is_mem || d_data !== e.data || d_cyc - g !== e.lat) begin
                tests_failed++;
                $display("FAIL conflict[%0d]: seen=%0b mem=%0b data=%h lat=%0d expected mem=%0b data=%h lat=%0d",
                         n, d_seen, d_mem, d_data, d_cyc - g, e.is_mem, e.data, e.lat);
            end
            $display("[TB] conflict done %0d mem=%0b data=%h latency=%0d", n, d_mem, d_data, d_cyc - g);
        end
        step();
    endtask

    task automatic test_flush();
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        g = cyc;
        step();
        step();
        bus.if_flush = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_len  = 2'b00;
        bus.mem_addr = 32'h3001;
        sb.push_back('{1'b1, 1'b1, 32'h000000F0, 6});
        step();
        bus.if_flush = 1'b0;
        bus.if_req   = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.busy_o !== 1'b0 || bus.if_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle: busy=%0b if_done=%0b expected 0 0", bus.busy_o, bus.if_done);
        end
        wait_done(10);
        e = sb.pop_front();
        tests_run++;
        if (d_seen !== 1'b1 || d_mem !== e.is_mem || d_data !== e.data || d_cyc - g !== e.lat) begin
            tests_failed++;
            $display("FAIL flush_mem: seen=%0b mem=%0b data=%h lat=%0d expected mem=1 data=%h lat=%0d",
                     d_seen, d_mem, d_data, d_cyc - g, e.data, e.lat);
        end
        $display("[TB] flush then mem byte load -> mem=%0b data=%h latency=%0d", d_mem, d_data, d_cyc - g);
        step();
    endtask

    task automatic test_reset_mid();
        step();
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_len   = 2'b10;
        bus.mem_addr  = 32'h6000;
        bus.mem_wdata = 32'h11223344;
        g = cyc;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.ram_wr !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_before: ram_wr=%0b expected 1", bus.ram_wr);
        end
        step();
        rst         = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.ram_a, bus.ram_wr, bus.ram_dout, bus.busy_o, bus.if_done, bus.mem_done, bus.if_data, bus.mem_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: a=%h wr=%0b dout=%h busy=%0b mem_done=%0b expected all 0",
                     bus.ram_a, bus.ram_wr, bus.ram_dout, bus.busy_o, bus.mem_done);
        end
        wait_done(8);
        tests_run++;
        if (d_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_nodone: done seen=%0b expected 0", d_seen);
        end
        $display("[TB] reset mid-store: done seen=%0b", d_seen);
        step();
    endtask

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_len   = 2'b00;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        test_reset();
        test_if_fetch();
        test_store_word();
        test_table();
        test_conflict();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates between instruction fetch (IF) and the MEM stage for one shared byte-wide RAM port. The arbiter serialises each 1/2/4-byte access into byte cycles and assembles read data into a word. It returns a one-cycle done pulse to the granted requester. It sits between the IF and MEM stages and the top-level RAM interface; ctrl uses busy_o as a stall source.

Parameters:
ADDR_W, 32, address width of requester and RAM addresses
RAM_RD_LAT, 1, RAM read latency in cycles; only 1 is supported, and values other than 1 are a synthesis error

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high (rst == `RstEnable)
if_req  in  1  IF read request; held high until if_done
if_addr  in  ADDR_W  IF word address; stable while if_req is high
if_flush  in  1  branch taken in EX; abort any pending or in-flight IF fetch
if_done  out  1  one-cycle pulse; if_data valid in the same cycle
if_data  out  32  fetched instruction word
mem_req  in  1  MEM request; held high until mem_done
mem_we  in  1  1 = store, 0 = load
mem_len  in  2  2'b00 = byte, 2'b01 = half, 2'b10 or 2'b11 = word
mem_addr  in  ADDR_W  byte address
mem_wdata  in  32  store data; byte 0 is sent first
mem_done  out  1  one-cycle pulse; mem_rdata valid in the same cycle for loads
mem_rdata  out  32  load data, zero-extended; the MEM stage sign-extends
ram_a  out  ADDR_W  RAM address
ram_wr  out  1  RAM write enable
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte, valid one cycle after ram_a
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs are 0; state = IDLE; cnt = 0; last_grant = IF.
- States:
  - IDLE: sample requests.
  - RD: issue read addresses and collect bytes.
  - WR: issue write bytes.
  - DONE: pulse done.
- Transfer length N: 1, 2 or 4 per mem_len. IF transfers are always N = 4.
- Grant (IDLE, cycle G):
  - If mem_req is high, grant MEM; otherwise, if if_req is high and if_flush is low, grant IF.
  - On grant, latch base address, N, we and wdata; cnt = 0.
  - Next state is WR for MEM with mem_we = 1, otherwise RD.
- RD (cycles G+1 .. G+N+1, cnt = 0..N):
  - If cnt < N: ram_a = base + cnt, ram_wr = 0.
  - If cnt >= 1: capture ram_din into data byte (cnt-1).
  - After cnt == N, go to DONE.
- WR (cycles G+1 .. G+N, cnt = 0..N-1): ram_a = base + cnt, ram_wr = 1, ram_dout = wdata byte cnt. After cnt == N-1, go to DONE.
- DONE: assert the granted requester's done for exactly 1 cycle with assembled data, then go to IDLE. ram_wr = 0.
- Latency from grant cycle G:
  - Word read: done at G+6.
  - Half read: done at G+4.
  - Byte read: done at G+3.
  - Word write: done at G+5.
  - Byte write: done at G+2.
- Requester rule: after seeing done in cycle D, the requester has req low by cycle D+1. IDLE at D+1 therefore does not re-grant.
- Data bytes not read (byte/half loads) are 0. Address arithmetic wraps modulo 2^ADDR_W.
- Flush:
  - if_flush high while state is RD with IF granted: return to IDLE at the next edge; no if_done; partial data is discarded.
  - if_flush has no effect on MEM transfers.
  - if_flush high in IDLE blocks the IF grant that cycle.
- Simultaneous if_flush and if_req in IDLE: no grant, unless MEM wins.
- Reset mid-transfer: the transfer is abandoned and no done is issued. ram_wr drops to 0 in the cycle after rst is sampled. A partial store is not rolled back.
- Outputs ram_a and ram_dout hold their last value in IDLE and DONE.

Optional Feature:
MEM_ARB_RR_EN
- Defined: when both requests are high in IDLE, grant the requester opposite to last_grant. last_grant updates on each grant. The first conflict after reset goes to MEM.
- Undefined: fixed priority; MEM always wins conflicts. The last_grant register is not built.

Test Plan:
- IF word fetch, if_addr = 0x100, RAM bytes 0x13, 0x00, 0x50, 0x00 -> ram_a = 0x100..0x103 on G+1..G+4; if_done at G+6 with if_data = 0x00500013.
- MEM store word 0xDEADBEEF at 0x2000 -> ram_wr high G+1..G+4; ram_dout = EF, BE, AD, DE; mem_done at G+5; busy_o is 0 at G+6.
- MEM load byte at 0x3001, RAM = 0xF0 -> one read; mem_done at G+3; mem_rdata = 0x000000F0.
- if_req and mem_req (word load) rise in the same cycle -> MEM served first; IF granted in the IDLE after mem_done. With MEM_ARB_RR_EN, a second simultaneous conflict goes to IF.
- IF fetch with if_flush pulsed at G+2 -> state is IDLE at G+3; if_done is never asserted; a pending mem_req is granted at G+3.
- rst asserted at G+2 of a word store -> the following cycle shows ram_wr = 0, busy_o = 0 and all outputs at 0; no mem_done.
